// File: rtl/cpri_pkg.sv
// Shared constants and types for the CPRI chip framer.
// Chip layout: head words, info words, then IQ words up to CHIP_WORDS-1.
package cpri_pkg;

    localparam int CHIP_WORDS = 91;
    localparam int HEAD_WORDS = 3;
    localparam int INFO_FIRST = 3;
    localparam int IQ_FIRST   = 7;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 64;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP,
        OVER
    } framer_state_t;

    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  wlast;
    } cpri_wr_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpri_chip_framer.sv
// Per-chip word framer feeding the CPRI RX loop buffer write port.
// Define CPRI_FRAMER_STATS_EN to build the chip/drop statistics counters.
module cpri_chip_framer
    import cpri_pkg::*;
#(
    parameter int CHIP_WORDS = cpri_pkg::CHIP_WORDS,
    parameter int ADDR_WIDTH = cpri_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpri_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = cpri_pkg::CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_sop,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_buf_ready,
    output logic                  o_cpri_wen,
    output logic [ADDR_WIDTH-1:0] o_cpri_waddr,
    output logic [DATA_WIDTH-1:0] o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic                  o_short_err,
    output logic                  o_long_err,
    output logic [CNT_WIDTH-1:0]  o_chip_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CHIP_WORDS - 1);

    framer_state_t         r_state, w_nxt_state;
    logic [ADDR_WIDTH-1:0] r_cnt, w_nxt_cnt;
    logic                  r_long_seen, w_nxt_long_seen;
    cpri_wr_t              r_wr, w_nxt_wr;
    logic                  r_short, w_nxt_short;
    logic                  r_long, w_nxt_long;

    logic w_sop;
    logic w_word;
    logic w_go;
    logic w_last;

    assign w_sop  = i_rx_valid & i_rx_sop;
    assign w_word = i_rx_valid & ~i_rx_sop;
    assign w_go   = i_enable & i_buf_ready;
    assign w_last = (r_cnt == LAST_ADDR);

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_long_seen = r_long_seen;
        w_nxt_wr        = '0;
        w_nxt_short     = 1'b0;
        w_nxt_long      = 1'b0;
        // Any sop restarts framing, whatever state we are in.
        if (w_sop) begin
            w_nxt_short = (r_state == FILL);
            if (w_go) begin
                w_nxt_wr.wen   = 1'b1;
                w_nxt_wr.wdata = i_rx_data;
                w_nxt_state    = FILL;
                w_nxt_cnt      = ADDR_WIDTH'(1);
            end else begin
                w_nxt_state = DROP;
                w_nxt_cnt   = '0;
            end
        end else if (w_word) begin
            unique case (r_state)
                FILL: begin
                    w_nxt_wr.wen   = 1'b1;
                    w_nxt_wr.waddr = r_cnt;
                    w_nxt_wr.wdata = i_rx_data;
                    w_nxt_wr.wlast = w_last;
                    w_nxt_cnt      = r_cnt + 1'b1;
                    if (w_last) begin
                        w_nxt_state     = OVER;
                        w_nxt_long_seen = 1'b0;
                    end
                end
                OVER: begin
                    if (!r_long_seen) begin
                        w_nxt_long      = 1'b1;
                        w_nxt_long_seen = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_seen <= 1'b0;
            r_wr        <= '0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_long_seen <= w_nxt_long_seen;
            r_wr        <= w_nxt_wr;
            r_short     <= w_nxt_short;
            r_long      <= w_nxt_long;
        end
    end

    assign o_cpri_wen   = r_wr.wen;
    assign o_cpri_waddr = r_wr.waddr;
    assign o_cpri_wdata = r_wr.wdata;
    assign o_cpri_wlast = r_wr.wlast;
    assign o_short_err  = r_short;
    assign o_long_err   = r_long;

`ifdef CPRI_FRAMER_STATS_EN
    logic w_chip_inc;
    logic w_drop_inc;

    assign w_chip_inc = w_word & (r_state == FILL) & w_last;
    assign w_drop_inc = w_sop & ~w_go;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_chip_cnt (
        .i_clk (i_clk),
        .i_clr (~i_reset_n),
        .i_inc (w_chip_inc),
        .o_cnt (o_chip_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .i_clk (i_clk),
        .i_clr (~i_reset_n),
        .i_inc (w_drop_inc),
        .o_cnt (o_drop_cnt)
    );
`else
    assign o_chip_cnt = '0;
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cpri_chip_framer.sv
// Scoreboard bench for cpri_chip_framer: directed chip scenarios plus
// randomized chip streams checked against a chip-level reference model.
module tb_cpri_chip_framer;
    import cpri_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic        i_rx_valid;
    logic        i_rx_sop;
    logic [63:0] i_rx_data;
    logic        i_buf_ready;
    logic        o_cpri_wen;
    logic [6:0]  o_cpri_waddr;
    logic [63:0] o_cpri_wdata;
    logic        o_cpri_wlast;
    logic        o_short_err;
    logic        o_long_err;
    logic [15:0] o_chip_cnt;
    logic [15:0] o_drop_cnt;

    always #5 i_clk = ~i_clk;

    cpri_chip_framer dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_enable     (i_enable),
        .i_rx_valid   (i_rx_valid),
        .i_rx_sop     (i_rx_sop),
        .i_rx_data    (i_rx_data),
        .i_buf_ready  (i_buf_ready),
        .o_cpri_wen   (o_cpri_wen),
        .o_cpri_waddr (o_cpri_waddr),
        .o_cpri_wdata (o_cpri_wdata),
        .o_cpri_wlast (o_cpri_wlast),
        .o_short_err  (o_short_err),
        .o_long_err   (o_long_err),
        .o_chip_cnt   (o_chip_cnt),
        .o_drop_cnt   (o_drop_cnt)
    );

    typedef struct {
        int          cyc;
        bit          wen;
        int          addr;
        logic [63:0] data;
        bit          last;
        bit          sh;
        bit          lg;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Chip-level model: are we inside an accepted chip, and at which word.
    bit m_open;
    bit m_over;
    bit m_lrep;
    int m_pos;
    int m_chips;
    int m_drops;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic model_clear();
        m_open  = 0;
        m_over  = 0;
        m_lrep  = 0;
        m_pos   = 0;
        m_chips = 0;
        m_drops = 0;
    endtask

    task automatic step(bit v, bit s, logic [63:0] d, bit rdy, bit en);
        exp_t e;
        bit   any;
        any    = 0;
        e.cyc  = cyc + 1;
        e.wen  = 0;
        e.addr = 0;
        e.data = '0;
        e.last = 0;
        e.sh   = 0;
        e.lg   = 0;
        i_rx_valid  = v;
        i_rx_sop    = s;
        i_rx_data   = d;
        i_buf_ready = rdy;
        i_enable    = en;
        if (v && s) begin
            if (m_open) begin
                e.sh = 1;
                any  = 1;
            end
            m_over = 0;
            if (en && rdy) begin
                e.wen  = 1;
                e.data = d;
                any    = 1;
                m_open = 1;
                m_pos  = 1;
            end else begin
                m_open = 0;
                if (m_drops < 65535) m_drops++;
            end
        end else if (v) begin
            if (m_open) begin
                e.wen  = 1;
                e.addr = m_pos;
                e.data = d;
                any    = 1;
                if (m_pos == CHIP_WORDS - 1) begin
                    e.last = 1;
                    m_open = 0;
                    m_over = 1;
                    m_lrep = 0;
                    if (m_chips < 65535) m_chips++;
                end
                m_pos++;
            end else if (m_over && !m_lrep) begin
                e.lg   = 1;
                any    = 1;
                m_lrep = 1;
            end
        end
        if (any) q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 1, 1);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_chip(int len, bit rdy, bit en, int gap_pct);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(99, 0) < gap_pct)
                step(0, $urandom_range(1, 0), rnd64(), 1'($urandom_range(1, 0)), en);
            step(1, i == 0, rnd64(), (i == 0) ? rdy : 1'($urandom_range(1, 0)), en);
        end
    endtask

    task automatic check_zero(string name);
        total++;
        if (o_cpri_wen || o_cpri_waddr != 0 || o_cpri_wdata != 0 || o_cpri_wlast
            || o_short_err || o_long_err || o_chip_cnt != 0 || o_drop_cnt != 0) begin
            bad++;
            $display("FAIL %s: wen=%0b addr=%0d last=%0b sh=%0b lg=%0b chip=%0d drop=%0d, required all 0",
                     name, o_cpri_wen, o_cpri_waddr, o_cpri_wlast, o_short_err, o_long_err,
                     o_chip_cnt, o_drop_cnt);
        end
    endtask

    task automatic do_reset(bit v);
        i_reset_n = 0;
        i_rx_valid = v;
        i_rx_sop = 0;
        i_rx_data = rnd64();
        model_clear();
        @(posedge i_clk);
        #1;
        i_reset_n = 1;
        i_rx_valid = 0;
        check_zero("reset");
    endtask

    task automatic check_cnt(string name);
        int ec;
        int ed;
`ifdef CPRI_FRAMER_STATS_EN
        ec = m_chips;
        ed = m_drops;
`else
        ec = 0;
        ed = 0;
`endif
        total++;
        if (o_chip_cnt != 16'(ec) || o_drop_cnt != 16'(ed)) begin
            bad++;
            $display("FAIL %s counters: chip=%0d drop=%0d, required chip=%0d drop=%0d",
                     name, o_chip_cnt, o_drop_cnt, ec, ed);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge i_clk) begin
        exp_t e;
        while (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing event: cycle %0d addr=%0d wen=%0b sh=%0b lg=%0b not seen",
                     e.cyc, e.addr, e.wen, e.sh, e.lg);
        end
        if (o_cpri_wen || o_short_err || o_long_err) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected event: cycle %0d wen=%0b addr=%0d sh=%0b lg=%0b, required none",
                         cyc, o_cpri_wen, o_cpri_waddr, o_short_err, o_long_err);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || o_cpri_wen != e.wen || o_cpri_wlast != e.last
                    || o_short_err != e.sh || o_long_err != e.lg
                    || (e.wen && (o_cpri_waddr != 7'(e.addr) || o_cpri_wdata != e.data))) begin
                    bad++;
                    $display("FAIL event: cyc=%0d wen=%0b addr=%0d data=%h last=%0b sh=%0b lg=%0b, required cyc=%0d wen=%0b addr=%0d data=%h last=%0b sh=%0b lg=%0b",
                             cyc, o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast,
                             o_short_err, o_long_err, e.cyc, e.wen, e.addr, e.data,
                             e.last, e.sh, e.lg);
                end
            end
        end
    end

    initial begin
        i_reset_n   = 0;
        i_enable    = 1;
        i_rx_valid  = 0;
        i_rx_sop    = 0;
        i_rx_data   = '0;
        i_buf_ready = 1;
        model_clear();
        @(posedge i_clk);
        #1;
        do_reset(0);

        send_chip(91, 1, 1, 0);
        idle(3);
        check_cnt("s1 full chip");

        for (int i = 0; i < 91; i++) begin
            if (i == 5 || i == 20 || i == 44 || i == 70 || i == 90) idle(1);
            step(1, i == 0, rnd64(), 1, 1);
        end
        idle(3);
        check_cnt("s2 gaps");

        do_reset(0);
        send_chip(40, 1, 1, 0);
        send_chip(91, 1, 1, 0);
        idle(3);
        check_cnt("s3 short");

        do_reset(0);
        send_chip(91, 0, 1, 0);
        send_chip(91, 1, 1, 0);
        idle(3);
        check_cnt("s4 drop");

        do_reset(0);
        send_chip(91, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, rnd64(), 1, 1);
        idle(3);
        check_cnt("s5 long");

        send_chip(50, 1, 1, 0);
        do_reset(1);
        send_chip(91, 1, 1, 0);
        idle(3);
        check_cnt("s6 reset mid-chip");

        for (int c = 0; c < 60; c++) begin
            int len;
            len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(100, 1)) : 91;
            send_chip(len, $urandom_range(5, 0) != 0, $urandom_range(7, 0) != 0, 10);
            if ($urandom_range(4, 0) == 0)
                for (int k = 0; k < int'($urandom_range(4, 1)); k++)
                    step(1, 0, rnd64(), 1, 1);
        end
        idle(4);
        check_cnt("random");

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d events left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
